// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single data RAM port: one access at a time,
// round-robin on conflict, out-of-range accesses rejected without strobing RAM.
module ram_arbiter #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        ram_r,
    output logic [3:0]  ram_w,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [29:0] LIMIT = 30'(WORDS);

    state_t      state, state_nxt;
    logic        last;
    logic        win_id;
    logic        err_q;
    logic [3:0]  we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        any_req;
    logic        grant_id;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        rd_ok;

    // On a conflict the master that did not win last time gets the port.
    always_comb begin
        any_req   = m0_req | m1_req;
        grant_id  = (m0_req && m1_req) ? ~last : m1_req;
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
        sel_err   = (sel_addr[31:2] >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            win_id  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            last    <= grant_id;
            win_id  <= grant_id;
            err_q   <= sel_err;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Strobes and acks are gated with !rst so a reset edge never commits
    // a write or completes a transfer.
    always_comb begin
        ram_r    = 1'b0;
        ram_w    = '0;
        ram_addr = '0;
        ram_in   = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        busy     = (state != IDLE);
        rd_ok    = !err_q && (we_q == 4'b0000);
        if (!rst) begin
            case (state)
                ACCESS: begin
                    if (!err_q) begin
                        ram_addr = addr_q;
                        ram_in   = wdata_q;
                        ram_w    = we_q;
                        ram_r    = (we_q == 4'b0000);
                    end
                end
                DONE: begin
                    if (win_id) begin
                        m1_ack   = 1'b1;
                        m1_err   = err_q;
                        m1_rdata = rd_ok ? ram_out : 32'h0;
                    end else begin
                        m0_ack   = 1'b1;
                        m0_err   = err_q;
                        m0_rdata = rd_ok ? ram_out : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, vector table of single accesses,
// and hand sequences for contention, held requests and reset mid-access.
module tb_ram_arbiter;

    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0]  m0_we = '0, m1_we = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_r;
    logic [3:0]  ram_w;
    logic [31:0] ram_addr, ram_in;
    logic [31:0] ram_out;
    logic        busy;

    ram_arbiter #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_in(ram_in),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data registered on the access edge.
    logic [31:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (ram_r) ram_out <= mem[ram_addr[13:2]];
        for (int b = 0; b < 4; b++)
            if (ram_w[b]) mem[ram_addr[13:2]][8*b +: 8] <= ram_in[8*b +: 8];
    end

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          m;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no ack within bound", name);
    endtask

    // Scoreboard consumer and strobe counters.
    always @(negedge clk) begin
        exp_t e;
        if (ram_r) rd_cnt++;
        if (|ram_w) wr_cnt++;
        if (m0_ack || m1_ack) begin
            chk("single_ack", 32'(m0_ack & m1_ack), 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
            end else begin
                e = sbq.pop_front();
                chk("ack_id", 32'(m1_ack), 32'(e.id));
                chk("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
                chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
                chk("other_side", m1_ack ? (m0_rdata | 32'(m0_err) | 32'(m0_ack))
                                         : (m1_rdata | 32'(m1_err) | 32'(m1_ack)), 32'd0);
            end
        end
    end

    task automatic set_m(input int m, input logic req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ram_r"}, 32'(ram_r), 32'd0);
        chk({tag, "_ram_w"}, 32'(ram_w), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr | ram_in, 32'd0);
        chk({tag, "_acks"}, 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'd0);
        chk({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    // One uncontended access; the request cycle, ACCESS and DONE make three cycles.
    task automatic do_access(input string name, input int m, input logic [3:0] we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic err, input logic [31:0] rdata);
        int  c0;
        bit  got;
        exp_t e;
        e.id = m; e.err = err; e.rdata = rdata;
        sbq.push_back(e);
        @(posedge clk); #1;
        set_m(m, 1'b1, we, addr, wdata);
        c0 = cyc;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1;
        end
        set_m(m, 1'b0, 4'h0, 32'h0, 32'h0);
        if (!got) fail_timeout(name);
        else chk({name, "_latency"}, 32'(cyc - c0), 32'd2);
    endtask

    initial begin
        int   r0, w0, n0, n1, c0, k;
        int   a0[3], a1[3], ha[2];
        exp_t e;

        vecs[0]  = '{0, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{0, 4'h0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 4'hF, 32'h20,   32'h11223344, 1'b0, 32'h0};
        vecs[3]  = '{1, 4'h2, 32'h20,   32'h0000AA00, 1'b0, 32'h0};
        vecs[4]  = '{1, 4'h0, 32'h20,   32'h0,        1'b0, 32'h1122AA44};
        vecs[5]  = '{1, 4'hF, 32'h4000, 32'h55555555, 1'b1, 32'h0};
        vecs[6]  = '{1, 4'hF, 32'h3FFC, 32'hA5A55A5A, 1'b0, 32'h0};
        vecs[7]  = '{1, 4'h0, 32'h3FFE, 32'h0,        1'b0, 32'hA5A55A5A};
        vecs[8]  = '{0, 4'h0, 32'h4000, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{0, 4'hF, 32'h30,   32'hCAFEF00D, 1'b0, 32'h0};
        vecs[10] = '{1, 4'h9, 32'h30,   32'h77000088, 1'b0, 32'h0};
        vecs[11] = '{0, 4'h0, 32'h30,   32'h0,        1'b0, 32'h77FEF088};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("init");

        for (int i = 0; i < 12; i++) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            do_access($sformatf("vec%0d", i), vecs[i].m, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].err, vecs[i].rdata);
            chk($sformatf("vec%0d_reads", i), 32'(rd_cnt - r0),
                32'(!vecs[i].err && vecs[i].we == 4'h0));
            chk($sformatf("vec%0d_writes", i), 32'(wr_cnt - w0),
                32'(!vecs[i].err && vecs[i].we != 4'h0));
        end

        // Request held through its ack is a second request.
        e = '{0, 1'b0, 32'hDEADBEEF};
        sbq.push_back(e);
        sbq.push_back(e);
        r0 = rd_cnt;
        @(posedge clk); #1;
        set_m(0, 1'b1, 4'h0, 32'h10, 32'h0);
        k = 0;
        for (int i = 0; i < 20 && k < 2; i++) begin
            @(negedge clk);
            if (m0_ack) begin
                ha[k] = cyc;
                k++;
            end
        end
        set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (k < 2) fail_timeout("held_req");
        else chk("held_gap", 32'(ha[1] - ha[0]), 32'd3);
        repeat (3) @(posedge clk);
        chk("held_reads", 32'(rd_cnt - r0), 32'd2);

        // Reset while a write to 0x30 is in ACCESS.
        w0 = wr_cnt;
        @(posedge clk); #1;
        set_m(0, 1'b1, 4'hF, 32'h30, 32'h12345678);
        @(posedge clk); #1;
        chk("mid_access_w", 32'(ram_w), 32'hF);
        rst = 1'b1;
        set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rst_gates_w", 32'(ram_w), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        repeat (6) @(negedge clk);
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);
        do_access("after_rst_read", 1, 4'h0, 32'h30, 32'h0, 1'b0, 32'h77FEF088);

        // Both masters requesting continuously from reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e = '{0, 1'b0, 32'hDEADBEEF};
            sbq.push_back(e);
            e = '{1, 1'b0, 32'h1122AA44};
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        set_m(0, 1'b1, 4'h0, 32'h10, 32'h0);
        set_m(1, 1'b1, 4'h0, 32'h20, 32'h0);
        c0 = cyc;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 60 && (n0 + n1) < 6; i++) begin
            @(negedge clk);
            if (m0_ack && n0 < 3) begin a0[n0] = cyc; n0++; end
            if (m1_ack && n1 < 3) begin a1[n1] = cyc; n1++; end
        end
        set_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
        if ((n0 + n1) < 6) begin
            fail_timeout("contention");
        end else begin
            chk("cont_first", 32'(a0[0] - c0), 32'd2);
            chk("cont_m0_gap1", 32'(a0[1] - a0[0]), 32'd6);
            chk("cont_m0_gap2", 32'(a0[2] - a0[1]), 32'd6);
            chk("cont_m1_gap1", 32'(a1[1] - a1[0]), 32'd6);
            chk("cont_m1_gap2", 32'(a1[2] - a1[1]), 32'd6);
            chk("cont_interleave", 32'(a1[0] - a0[0]), 32'd3);
        end

        repeat (6) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
